// File: rtl/phys_mem_ctrl.sv
// Asynchronous-SRAM controller with a one-word mirror: hits complete with no busy cycle,
// misses run a read or setup/pulse/hold write cycle with a WAIT_CYCLES-long strobe.
module phys_mem_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_data_in,
   input  logic        mem_is_write,
   output logic [31:0] mem_data_out,
   output logic        mem_busy,
   output logic [19:0] sram_addr,
   input  logic [31:0] sram_dq_i,
   output logic [31:0] sram_dq_o,
   output logic        sram_dq_oe,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StWrSetup,
      StWrPulse,
      StWrHold
   } state_e;

   localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

   state_e      r_state;
   state_e      w_state_d;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_d;
   logic        r_last_valid;
   logic [19:0] r_last_addr;
   logic [31:0] r_last_data;
   logic [19:0] r_sram_addr;
   logic [31:0] r_sram_dq_o;
   logic        r_dq_oe;
   logic        r_ce_n;
   logic        r_oe_n;
   logic        r_we_n;
   logic [19:0] w_req_addr;
   logic        w_new_req;
   logic        w_accept;
   logic        w_cnt_done;
   logic        w_unused_addr;

   assign w_req_addr    = mem_addr[21:2];
   assign w_unused_addr = ^{mem_addr[31:22], mem_addr[1:0]};
   assign w_new_req     = !r_last_valid || (w_req_addr != r_last_addr) ||
                          (mem_is_write && (mem_data_in != r_last_data));
   assign w_accept      = (r_state == StIdle) && w_new_req;
   assign w_cnt_done    = (r_cnt == 4'd0);
   assign mem_busy      = !rst && ((r_state != StIdle) || w_new_req);

   assign mem_data_out = r_last_data;
   assign sram_addr    = r_sram_addr;
   assign sram_dq_o    = r_sram_dq_o;
   assign sram_dq_oe   = r_dq_oe;
   assign sram_ce_n    = r_ce_n;
   assign sram_oe_n    = r_oe_n;
   assign sram_we_n    = r_we_n;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (w_new_req) begin
               w_state_d = mem_is_write ? StWrSetup : StRd;
               w_cnt_d   = CntLoad;
            end
         end
         StRd: begin
            if (w_cnt_done) w_state_d = StIdle;
            else            w_cnt_d   = r_cnt - 4'd1;
         end
         StWrSetup: w_state_d = StWrPulse;
         StWrPulse: begin
            if (w_cnt_done) w_state_d = StWrHold;
            else            w_cnt_d   = r_cnt - 4'd1;
         end
         StWrHold: w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   // Strobes are decoded from the next state so the pins match the state they are in.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_cnt        <= 4'd0;
         r_last_valid <= 1'b0;
         r_last_addr  <= 20'd0;
         r_last_data  <= 32'd0;
         r_sram_addr  <= 20'd0;
         r_sram_dq_o  <= 32'd0;
         r_dq_oe      <= 1'b0;
         r_ce_n       <= 1'b1;
         r_oe_n       <= 1'b1;
         r_we_n       <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_accept) begin
            r_sram_addr <= w_req_addr;
            if (mem_is_write) r_sram_dq_o <= mem_data_in;
         end
         if ((r_state == StRd) && w_cnt_done) begin
            r_last_valid <= 1'b1;
            r_last_addr  <= r_sram_addr;
            r_last_data  <= sram_dq_i;
         end
         if (r_state == StWrHold) begin
            r_last_valid <= 1'b1;
            r_last_addr  <= r_sram_addr;
            r_last_data  <= r_sram_dq_o;
         end
         r_ce_n  <= (w_state_d == StIdle);
         r_oe_n  <= (w_state_d != StRd);
         r_we_n  <= (w_state_d != StWrPulse);
         r_dq_oe <= (w_state_d == StWrSetup) || (w_state_d == StWrPulse) ||
                    (w_state_d == StWrHold);
      end
   end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Bench for phys_mem_ctrl: three instances (WAIT_CYCLES 2, 1, 15), each with an SRAM model,
// a transaction-level reference model checked every cycle, and directed literal checks.
module tb_phys_mem_ctrl;

   logic clk = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int W      = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      localparam int RdBusy = (g == 0) ? 3 : (g == 1) ? 2 : 16;
      localparam int WrBusy = (g == 0) ? 5 : (g == 1) ? 4 : 18;

      logic        rst;
      logic [31:0] mem_addr;
      logic [31:0] mem_data_in;
      logic        mem_is_write;
      logic [31:0] mem_data_out;
      logic        mem_busy;
      logic [19:0] sram_addr;
      logic [31:0] sram_dq_i;
      logic [31:0] sram_dq_o;
      logic        sram_dq_oe;
      logic        sram_ce_n;
      logic        sram_oe_n;
      logic        sram_we_n;
      logic [31:0] sram_mem [1024];
      bit          init_done = 1'b0;
      bit          done_f = 1'b0;
      string       pfx;

      phys_mem_ctrl #(.WAIT_CYCLES(W)) dut (
         .clk          (clk),
         .rst          (rst),
         .mem_addr     (mem_addr),
         .mem_data_in  (mem_data_in),
         .mem_is_write (mem_is_write),
         .mem_data_out (mem_data_out),
         .mem_busy     (mem_busy),
         .sram_addr    (sram_addr),
         .sram_dq_i    (sram_dq_i),
         .sram_dq_o    (sram_dq_o),
         .sram_dq_oe   (sram_dq_oe),
         .sram_ce_n    (sram_ce_n),
         .sram_oe_n    (sram_oe_n),
         .sram_we_n    (sram_we_n)
      );

      // SRAM model: reads drive the bus only with CE and OE low, writes land while WE is low.
      assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[9:0]] : 32'h0BAD_0BAD;

      always @(posedge clk) begin
         if (!init_done) begin
            for (int i = 0; i < 1024; i++)
               sram_mem[i] <= (i == 16) ? 32'hDEAD_BEEF : ((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234);
            init_done <= 1'b1;
         end else if (!sram_ce_n && !sram_we_n) begin
            sram_mem[sram_addr[9:0]] <= sram_dq_o;
         end
      end

      // Reference model: mirror contents plus position k inside the access in progress.
      bit          m_on = 1'b0;
      bit          m_valid;
      logic [19:0] m_addr;
      logic [31:0] m_data;
      int          m_k;
      bit          m_wr;
      logic [19:0] m_txa;
      logic [31:0] m_txd;

      always @(negedge clk) begin
         int          len;
         logic [19:0] aw;
         bit          nw;
         if (!m_on) begin
            if (rst === 1'b1) begin
               m_on = 1'b1; m_valid = 1'b0; m_addr = '0; m_data = '0; m_k = 0; m_wr = 1'b0;
            end
         end else begin
            len = m_wr ? W + 2 : W;
            check({pfx, " ce_n"},  32'(sram_ce_n),  32'(m_k == 0));
            check({pfx, " oe_n"},  32'(sram_oe_n),  32'(!(m_k > 0 && !m_wr)));
            check({pfx, " we_n"},  32'(sram_we_n),  32'(!(m_wr && m_k >= 2 && m_k <= W + 1)));
            check({pfx, " dq_oe"}, 32'(sram_dq_oe), 32'(m_wr && m_k > 0));
            check({pfx, " oe_we_overlap"}, 32'(!sram_oe_n && !sram_we_n), 32'd0);
            check({pfx, " dqoe_with_oe"},  32'(sram_dq_oe && !sram_oe_n), 32'd0);
            check({pfx, " data_out"}, mem_data_out, m_data);
            if (m_k > 0) check({pfx, " sram_addr"}, 32'(sram_addr), 32'(m_txa));
            if (m_k > 0 && m_wr) check({pfx, " sram_dq_o"}, sram_dq_o, m_txd);
            if (rst) begin
               check({pfx, " busy_in_rst"}, 32'(mem_busy), 32'd0);
               m_valid = 1'b0; m_addr = '0; m_data = '0; m_k = 0; m_wr = 1'b0;
            end else if (m_k == 0) begin
               aw = mem_addr[21:2];
               nw = !m_valid || (aw != m_addr) || (mem_is_write && mem_data_in != m_data);
               check({pfx, " busy_idle"}, 32'(mem_busy), 32'(nw));
               if (nw) begin
                  m_wr  = mem_is_write;
                  m_txa = aw;
                  m_txd = mem_is_write ? mem_data_in : sram_mem[aw[9:0]];
                  m_k   = 1;
               end
            end else begin
               check({pfx, " busy_active"}, 32'(mem_busy), 32'd1);
               if (m_k == len) begin
                  if (m_wr) check({pfx, " sram_word"}, sram_mem[m_txa[9:0]], m_txd);
                  m_valid = 1'b1; m_addr = m_txa; m_data = m_txd; m_k = 0;
               end else begin
                  m_k++;
               end
            end
         end
      end

      task automatic nxt();
         @(posedge clk);
         #1;
      endtask

      // Present a request (caller positioned just after an edge) and wait for mem_busy=0.
      task automatic do_req(input logic [31:0] a, input logic [31:0] d, input bit w,
                            output int nb, output int nwe, output int noe, output int nce);
         nb = 0; nwe = 0; noe = 0; nce = 0;
         mem_addr = a; mem_data_in = d; mem_is_write = w;
         for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!sram_we_n) nwe++;
            if (!sram_oe_n) noe++;
            if (!sram_ce_n) nce++;
            if (!mem_busy) return;
            nb++;
            @(posedge clk);
         end
         check({pfx, " request_timeout"}, 32'd1, 32'd0);
      endtask

      initial begin
         int          nb, nwe, noe, nce;
         logic [31:0] a;
         pfx = $sformatf("W%0d", W);
         rst = 1'b1; mem_addr = '0; mem_data_in = '0; mem_is_write = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk);
         check({pfx, " rst_busy"},   32'(mem_busy),  32'd0);
         check({pfx, " rst_ce_n"},   32'(sram_ce_n), 32'd1);
         check({pfx, " rst_data"},   mem_data_out,   32'd0);
         check({pfx, " rst_addr"},   32'(sram_addr), 32'd0);
         check({pfx, " rst_dq_o"},   sram_dq_o,      32'd0);

         // Read miss of word 0x10.
         nxt(); rst = 1'b0;
         do_req(32'h40, 32'h0, 1'b0, nb, nwe, noe, nce);
         check({pfx, " rd_miss_busy"}, 32'(nb), 32'(RdBusy));
         check({pfx, " rd_miss_oe"},   32'(noe), 32'(W));
         check({pfx, " rd_miss_data"}, mem_data_out, 32'hDEAD_BEEF);

         // Read hit.
         nxt(); do_req(32'h40, 32'h0, 1'b0, nb, nwe, noe, nce);
         check({pfx, " rd_hit_busy"}, 32'(nb), 32'd0);
         check({pfx, " rd_hit_ce"},   32'(nce), 32'd0);

         // Write then read back.
         nxt(); do_req(32'h80, 32'h1234_5678, 1'b1, nb, nwe, noe, nce);
         check({pfx, " wr_busy"},  32'(nb), 32'(WrBusy));
         check({pfx, " wr_we"},    32'(nwe), 32'(W));
         check({pfx, " wr_addr"},  32'(sram_addr), 32'h0002_0);
         check({pfx, " wr_mem"},   sram_mem[32], 32'h1234_5678);
         nxt(); do_req(32'h80, 32'h0, 1'b0, nb, nwe, noe, nce);
         check({pfx, " wr_rd_busy"}, 32'(nb), 32'd0);
         check({pfx, " wr_rd_data"}, mem_data_out, 32'h1234_5678);

         // Input churn during a write; original request restored for the first idle cycle.
         nxt(); mem_addr = 32'h100; mem_data_in = 32'hCAFE_F00D; mem_is_write = 1'b1;
         @(posedge clk);
         for (int i = 0; i < W + 2; i++) begin
            #1; mem_addr = $urandom; mem_data_in = $urandom; mem_is_write = 1'($urandom);
            @(posedge clk);
         end
         #1; mem_addr = 32'h100; mem_data_in = 32'hCAFE_F00D; mem_is_write = 1'b1;
         @(negedge clk);
         check({pfx, " churn_busy"}, 32'(mem_busy), 32'd0);
         check({pfx, " churn_mem"},  sram_mem[64], 32'hCAFE_F00D);
         check({pfx, " churn_addr"}, 32'(sram_addr), 32'h40);
         check({pfx, " churn_data"}, mem_data_out, 32'hCAFE_F00D);

         // Reset abort of a read miss, then the full miss again.
         nxt(); mem_addr = 32'h200; mem_data_in = '0; mem_is_write = 1'b0;
         @(posedge clk);
         if (W >= 2) @(posedge clk);
         #1; rst = 1'b1;
         nxt(); rst = 1'b0;
         check({pfx, " abort_ce_n"}, 32'(sram_ce_n), 32'd1);
         check({pfx, " abort_oe_n"}, 32'(sram_oe_n), 32'd1);
         check({pfx, " abort_data"}, mem_data_out, 32'd0);
         do_req(32'h200, 32'h0, 1'b0, nb, nwe, noe, nce);
         check({pfx, " abort_reread_busy"}, 32'(nb), 32'(RdBusy));
         check({pfx, " abort_reread_data"}, mem_data_out, sram_mem[128]);

         // Random traffic over a small address/data set so hits, misses and resets all occur.
         for (int c = 0; c < 600; c++) begin
            nxt();
            rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0) begin
               a = $urandom;
               a[21:2] = 20'($urandom_range(0, 31));
               mem_addr     = a;
               mem_data_in  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
               mem_is_write = ($urandom_range(0, 2) == 0);
            end
         end
         nxt(); rst = 1'b0;
         repeat (W + 6) @(posedge clk);
         done_f = 1'b1;
      end
   end

   initial begin
      for (int c = 0; c < 90000; c++) begin
         @(posedge clk);
         if (g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f) break;
      end
      if (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f))
         check("bench_timeout", 32'd1, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/phys_mem_ctrl.md
PHYS_MEM_CTRL -- requirements
Module: phys_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2: number of cycles the external SRAM strobe (OE_n or WE_n) is held low; legal range 1-15.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- mem_addr  in  32  byte address from the CPU; bits [21:2] are used, all other bits are ignored.
- mem_data_in  in  32  write data from the CPU.
- mem_is_write  in  1  1 = write request, 0 = read request.
- mem_data_out  out  32  read data to the CPU.
- mem_busy  out  1  CPU must hold its request while this is 1.
- sram_addr  out  20  SRAM word address.
- sram_dq_i  in  32  SRAM data bus input.
- sram_dq_o  out  32  SRAM data bus output.
- sram_dq_oe  out  1  1 = drive sram_dq_o onto the bus.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Function
REQ-004 The block SHALL hold a one-word mirror consisting of last_valid, last_addr[19:0] and last_data[31:0]; mem_data_out SHALL equal last_data at all times.
REQ-005 In IDLE, a new request SHALL be recognised when any of the following holds:
- last_valid=0;
- mem_addr[21:2] != last_addr;
- mem_is_write=1 and mem_data_in != last_data.
REQ-006 mem_busy SHALL be combinational: it is 1 when the state is not IDLE, or when the state is IDLE and a new request is recognised; it is 0 otherwise, and 0 whenever rst=1.
REQ-007 A read that hits the mirror, or a write whose address and data both equal the mirror, SHALL complete in zero cycles, with mem_busy=0 and no SRAM activity.
REQ-008 On the edge that accepts a request, the block SHALL register sram_addr=mem_addr[21:2], and for a write it SHALL also register sram_dq_o=mem_data_in.
REQ-009 The state machine SHALL have five states:
- IDLE;
- RD: WAIT_CYCLES cycles;
- WR_SETUP: 1 cycle;
- WR_PULSE: WAIT_CYCLES cycles;
- WR_HOLD: 1 cycle.
A counter SHALL time RD and WR_PULSE.
REQ-010 Transitions SHALL be:
- IDLE goes to RD on an accepted read, and to WR_SETUP on an accepted write;
- RD goes to IDLE after its last cycle;
- WR_SETUP goes to WR_PULSE;
- WR_PULSE goes to WR_HOLD after its last cycle;
- WR_HOLD goes to IDLE.
REQ-011 SRAM pins SHALL be registered and take these values per state:
- RD: ce_n=0, oe_n=0, we_n=1, dq_oe=0.
- WR_SETUP: ce_n=0, oe_n=1, we_n=1, dq_oe=1.
- WR_PULSE: ce_n=0, oe_n=1, we_n=0, dq_oe=1.
- WR_HOLD: ce_n=0, oe_n=1, we_n=1, dq_oe=1.
- IDLE: ce_n=1, oe_n=1, we_n=1, dq_oe=0.
REQ-012 On the final RD edge, the block SHALL capture sram_dq_i into last_data, set last_addr=sram_addr and set last_valid=1.
REQ-013 On the WR_HOLD edge, the block SHALL set last_data=sram_dq_o, last_addr=sram_addr and last_valid=1.
REQ-014 Latency SHALL be as follows: a read miss holds mem_busy=1 for exactly WAIT_CYCLES+1 cycles, and a write holds mem_busy=1 for exactly WAIT_CYCLES+3 cycles.
REQ-015 In the first cycle with mem_busy=0 after a read, mem_data_out SHALL carry the read word.
REQ-016 Request inputs SHALL be sampled only in IDLE; changes to mem_addr, mem_data_in or mem_is_write while not in IDLE SHALL have no effect on the access in progress.
REQ-017 WE_n and OE_n SHALL never be low in the same cycle, and dq_oe SHALL never be 1 while oe_n=0.
REQ-018 A request presented in the first IDLE cycle after completion SHALL be evaluated against the updated mirror, giving back-to-back accesses with no idle bubble on a miss.

Reset
REQ-019 While rst=1 at a clock edge, the block SHALL set the state to IDLE, counter=0, last_valid=0, last_addr=0 and last_data=0 (so mem_data_out=0).
REQ-020 While rst=1 at a clock edge, the block SHALL set sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1 and sram_we_n=1.
REQ-021 Reset asserted in the middle of an access SHALL abort that access within one edge, leaving last_valid=0 and all SRAM strobes inactive; a write aborted in WR_PULSE is accepted as corrupting that word.

Verification
REQ-022 Read miss (WAIT_CYCLES=2): SRAM model returns 0xDEADBEEF at word 0x00010, read mem_addr=0x40 -> mem_busy=1 for 3 cycles, oe_n low for 2 cycles, then mem_data_out=0xDEADBEEF with mem_busy=0.
REQ-023 Read hit: repeat the read of 0x40 with no SRAM change -> mem_busy stays 0 and ce_n stays 1.
REQ-024 Write then read: write 0x12345678 to 0x80 -> mem_busy=1 for 5 cycles, we_n low for exactly 2 cycles with sram_addr=0x00020; a subsequent read of 0x80 hits with 0x12345678, and the SRAM model holds 0x12345678.
REQ-025 Input churn: change mem_addr and mem_is_write every cycle during a write -> the SRAM receives the originally sampled address and data only; the pin-legality invariants of REQ-017 hold throughout.
REQ-026 Reset abort: assert rst in the 2nd RD cycle -> the next cycle shows ce_n=oe_n=1 and mem_data_out=0; re-reading the same address gives a full miss of 3 busy cycles.
REQ-027 Parameter sweep: repeat REQ-022 and REQ-024 with WAIT_CYCLES=1 and 15 -> busy durations are 2/4 and 16/18 cycles respectively.
